// File: rtl/coherent_sampler_counter.sv
`default_nettype none
// ============================================================================
// Module   : coherent_sampler_counter
// Brief    : Synchronises and debounces the coherent-sampler bit, measures the
//            beat period between accepted rising edges and offers it to the
//            configuration matching controller over a req/ack handshake.
//            Optional macro CS_DROP_CNT_EN adds a dropped-measurement counter.
// Revision : 1.0 - initial release
// ============================================================================
module coherent_sampler_counter #(
  parameter int CSCntLength   = 16,
  parameter int FilterLen     = 2,
  parameter int DropCntLength = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sampleIn_i,
  input  logic                     restart_i,
  output logic [CSCntLength-1:0]   CSCnt_o,
  output logic                     CSReq_o,
  input  logic                     CSAck_i
`ifdef CS_DROP_CNT_EN
  ,
  output logic [DropCntLength-1:0] dropCnt_o
`endif
);

  localparam logic [3:0] c_RUN_LAST = 4'(FilterLen - 1);

  if (FilterLen < 1 || FilterLen > 15 || DropCntLength < 1) begin : g_param_check
    $error("coherent_sampler_counter: FilterLen must be 1..15 and DropCntLength >= 1");
  end

  typedef enum logic [0:0] {
    WAIT_FIRST = 1'b0,
    RUN        = 1'b1
  } state_t;

  logic                   sync1_q;
  logic                   sync2_q;
  logic                   filt_q;
  logic                   filt_d;
  logic                   filt_prev_q;
  logic [3:0]             run_q;
  logic [3:0]             run_d;
  state_t                 state_q;
  state_t                 state_d;
  logic [CSCntLength-1:0] cnt_q;
  logic [CSCntLength-1:0] cnt_d;
  logic [CSCntLength-1:0] cs_cnt_q;
  logic [CSCntLength-1:0] cs_cnt_d;
  logic                   cs_req_q;
  logic                   cs_req_d;
  logic                   w_event;

`ifdef CS_DROP_CNT_EN
  logic [DropCntLength-1:0] drop_q;
  logic [DropCntLength-1:0] drop_d;
`endif

  // The run counter only advances while the synchronised level disagrees.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (sync2_q != filt_q) begin
      if (run_q == c_RUN_LAST) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  assign w_event = filt_q & ~filt_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cs_cnt_d = cs_cnt_q;
    cs_req_d = cs_req_q & ~CSAck_i;
`ifdef CS_DROP_CNT_EN
    drop_d   = drop_q;
`endif
    if (restart_i) begin
      state_d  = WAIT_FIRST;
      cnt_d    = '0;
      cs_req_d = 1'b0;
`ifdef CS_DROP_CNT_EN
      drop_d   = '0;
`endif
    end else begin
      case (state_q)
        WAIT_FIRST: begin
          if (w_event) begin
            state_d = RUN;
            cnt_d   = CSCntLength'(1);
          end
        end
        RUN: begin
          if (w_event) begin
            cnt_d = CSCntLength'(1);
            // An ack on the event edge frees the slot for the new value.
            if (!cs_req_q || CSAck_i) begin
              cs_cnt_d = cnt_q;
              cs_req_d = 1'b1;
            end else begin
`ifdef CS_DROP_CNT_EN
              if (drop_q != '1) begin
                drop_d = drop_q + DropCntLength'(1);
              end
`endif
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CSCntLength'(1);
          end
        end
        default: begin
          state_d = WAIT_FIRST;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      run_q       <= '0;
      state_q     <= WAIT_FIRST;
      cnt_q       <= '0;
      cs_cnt_q    <= '0;
      cs_req_q    <= 1'b0;
`ifdef CS_DROP_CNT_EN
      drop_q      <= '0;
`endif
    end else begin
      sync1_q     <= sampleIn_i;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      run_q       <= run_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_cnt_q    <= cs_cnt_d;
      cs_req_q    <= cs_req_d;
`ifdef CS_DROP_CNT_EN
      drop_q      <= drop_d;
`endif
    end
  end

  assign CSCnt_o = cs_cnt_q;
  assign CSReq_o = cs_req_q;
`ifdef CS_DROP_CNT_EN
  assign dropCnt_o = drop_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coherent_sampler_counter.sv
`default_nettype none
// Directed testbench for coherent_sampler_counter: periodic edges, glitches,
// backpressure, simultaneous ack, restart, async reset and saturation.
module tb_coherent_sampler_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        sampleIn;
  logic        restart;
  logic        CSAck;
  logic [15:0] CSCnt;
  logic        CSReq;
`ifdef CS_DROP_CNT_EN
  logic [7:0]  dropCnt;
  logic [7:0]  s_drop;
`endif
  logic        s_in;
  logic        s_ack;
  logic        s_restart;
  logic [7:0]  s_cnt;
  logic        s_req;

  int          n_cmp = 0;
  int          n_err = 0;
  logic        last_req;
  int          rk;
  int          nr;
  logic [15:0] rc;
  logic        rp;

  always #5 clk = ~clk;

  coherent_sampler_counter #(
    .CSCntLength(16), .FilterLen(2), .DropCntLength(8)
  ) u_dut (
    .clk(clk), .rst(rst), .sampleIn_i(sampleIn), .restart_i(restart),
    .CSCnt_o(CSCnt), .CSReq_o(CSReq), .CSAck_i(CSAck)
`ifdef CS_DROP_CNT_EN
    , .dropCnt_o(dropCnt)
`endif
  );

  coherent_sampler_counter #(
    .CSCntLength(8), .FilterLen(2), .DropCntLength(8)
  ) u_sat (
    .clk(clk), .rst(rst), .sampleIn_i(s_in), .restart_i(s_restart),
    .CSCnt_o(s_cnt), .CSReq_o(s_req), .CSAck_i(s_ack)
`ifdef CS_DROP_CNT_EN
    , .dropCnt_o(s_drop)
`endif
  );

  // One beat period of P cycles starting with a rising edge at k=0.
  task automatic do_period(input int P, input bit auto_ack, input int ack_at,
                           input int glitch_at, input int restart_at,
                           output int req_k, output logic [15:0] cnt_at_req,
                           output int nreq, output logic req_post_rst);
    req_k        = -1;
    cnt_at_req   = '0;
    nreq         = 0;
    req_post_rst = 1'b1;
    for (int k = 0; k < P; k++) begin
      @(negedge clk);
      if (CSReq && !last_req) begin
        nreq++;
        if (req_k < 0) begin
          req_k      = k;
          cnt_at_req = CSCnt;
        end
      end
      if (k == restart_at + 1) req_post_rst = CSReq;
      last_req = CSReq;
      sampleIn = (k < P / 2) || (k == glitch_at);
      CSAck    = (auto_ack && CSReq) || (k == ack_at);
      restart  = (k == restart_at);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; sampleIn = 1'b0; restart = 1'b0; CSAck = 1'b0;
    s_in = 1'b0; s_ack = 1'b0; s_restart = 1'b0; last_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (CSCnt !== 16'd0) begin n_err++; $display("FAIL reset_cscnt: got %0d expected 0", CSCnt); end
    n_cmp++; if (CSReq !== 1'b0) begin n_err++; $display("FAIL reset_csreq: got %0b expected 0", CSReq); end
`ifdef CS_DROP_CNT_EN
    n_cmp++; if (dropCnt !== 8'd0) begin n_err++; $display("FAIL reset_dropcnt: got %0d expected 0", dropCnt); end
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_periodic;
    do_period(37, 1'b1, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rk !== -1) begin n_err++; $display("FAIL periodic_first_noreq: got req at %0d expected none", rk); end
    for (int i = 0; i < 2; i++) begin
      do_period(37, 1'b1, -1, -1, -1, rk, rc, nr, rp);
      n_cmp++; if (rk !== 5) begin n_err++; $display("FAIL periodic_latency: got %0d expected 5", rk); end
      n_cmp++; if (rc !== 16'd37) begin n_err++; $display("FAIL periodic_cscnt: got %0d expected 37", rc); end
    end
  endtask

  task automatic test_glitch;
    logic [15:0] exp_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_cnt = (i == 0) ? 16'd37 : 16'd50;
      do_period(50, 1'b1, -1, 35, -1, rk, rc, nr, rp);
      n_cmp++; if (rk !== 5) begin n_err++; $display("FAIL glitch_latency: got %0d expected 5", rk); end
      n_cmp++; if (rc !== exp_cnt) begin n_err++; $display("FAIL glitch_cscnt: got %0d expected %0d", rc, exp_cnt); end
      n_cmp++; if (nr !== 1) begin n_err++; $display("FAIL glitch_nreq: got %0d expected 1", nr); end
    end
  endtask

  task automatic test_backpressure;
    do_period(20, 1'b1, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd50) begin n_err++; $display("FAIL bp_prev_cscnt: got %0d expected 50", rc); end
    do_period(20, 1'b0, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd20 || rk !== 5) begin n_err++; $display("FAIL bp_first_capture: got %0d@%0d expected 20@5", rc, rk); end
    do_period(20, 1'b0, -1, -1, -1, rk, rc, nr, rp);
    do_period(20, 1'b0, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (CSReq !== 1'b1 || CSCnt !== 16'd20) begin n_err++; $display("FAIL bp_hold: got req=%0b cnt=%0d expected req=1 cnt=20", CSReq, CSCnt); end
    do_period(20, 1'b0, 15, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (CSReq !== 1'b0 || CSCnt !== 16'd20) begin n_err++; $display("FAIL bp_after_ack: got req=%0b cnt=%0d expected req=0 cnt=20", CSReq, CSCnt); end
`ifdef CS_DROP_CNT_EN
    n_cmp++; if (dropCnt !== 8'd3) begin n_err++; $display("FAIL bp_dropcnt: got %0d expected 3", dropCnt); end
`endif
    do_period(20, 1'b1, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd20 || rk !== 5) begin n_err++; $display("FAIL bp_next_capture: got %0d@%0d expected 20@5", rc, rk); end
  endtask

  task automatic test_back_to_back;
    do_period(30, 1'b0, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd20) begin n_err++; $display("FAIL b2b_setup: got %0d expected 20", rc); end
    do_period(25, 1'b0, 4, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (CSReq !== 1'b1 || CSCnt !== 16'd30) begin n_err++; $display("FAIL b2b_simul: got req=%0b cnt=%0d expected req=1 cnt=30", CSReq, CSCnt); end
`ifdef CS_DROP_CNT_EN
    n_cmp++; if (dropCnt !== 8'd3) begin n_err++; $display("FAIL b2b_dropcnt: got %0d expected 3", dropCnt); end
`endif
    do_period(20, 1'b1, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd25) begin n_err++; $display("FAIL b2b_next: got %0d expected 25", rc); end
  endtask

  task automatic test_restart;
    do_period(20, 1'b0, -1, -1, 10, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd20) begin n_err++; $display("FAIL rs_capture: got %0d expected 20", rc); end
    n_cmp++; if (rp !== 1'b0) begin n_err++; $display("FAIL rs_req_drop: got %0b expected 0", rp); end
    n_cmp++; if (CSCnt !== 16'd20) begin n_err++; $display("FAIL rs_cscnt_kept: got %0d expected 20", CSCnt); end
`ifdef CS_DROP_CNT_EN
    n_cmp++; if (dropCnt !== 8'd0) begin n_err++; $display("FAIL rs_dropcnt: got %0d expected 0", dropCnt); end
`endif
    do_period(23, 1'b1, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rk !== -1) begin n_err++; $display("FAIL rs_first_noreq: got req at %0d expected none", rk); end
    do_period(20, 1'b1, -1, -1, -1, rk, rc, nr, rp);
    n_cmp++; if (rc !== 16'd23 || rk !== 5) begin n_err++; $display("FAIL rs_following: got %0d@%0d expected 23@5", rc, rk); end
  endtask

  task automatic test_async_reset;
    do_period(20, 1'b0, -1, -1, -1, rk, rc, nr, rp);
    @(negedge clk);
    n_cmp++; if (CSReq !== 1'b1 || CSCnt !== 16'd20) begin n_err++; $display("FAIL ar_pre: got req=%0b cnt=%0d expected req=1 cnt=20", CSReq, CSCnt); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (CSReq !== 1'b0 || CSCnt !== 16'd0) begin n_err++; $display("FAIL ar_immediate: got req=%0b cnt=%0d expected req=0 cnt=0", CSReq, CSCnt); end
`ifdef CS_DROP_CNT_EN
    n_cmp++; if (dropCnt !== 8'd0) begin n_err++; $display("FAIL ar_dropcnt: got %0d expected 0", dropCnt); end
`endif
    @(negedge clk);
    rst = 1'b0; sampleIn = 1'b0; CSAck = 1'b0; restart = 1'b0; last_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_saturation;
    for (int k = 0; k < 510; k++) begin
      @(negedge clk);
      if (k == 306) begin
        n_cmp++; if (s_req !== 1'b1 || s_cnt !== 8'd255) begin n_err++; $display("FAIL sat_cscnt: got req=%0b cnt=%0d expected req=1 cnt=255", s_req, s_cnt); end
      end
      if (k == 312) begin
        n_cmp++; if (s_req !== 1'b0) begin n_err++; $display("FAIL sat_ack: got %0b expected 0", s_req); end
      end
      if (k == 506) begin
        n_cmp++; if (s_req !== 1'b1 || s_cnt !== 8'd200) begin n_err++; $display("FAIL sat_unsat: got req=%0b cnt=%0d expected req=1 cnt=200", s_req, s_cnt); end
      end
      s_in  = (k < 150) || (k >= 300 && k < 400) || (k >= 500);
      s_ack = (k == 310);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_periodic();
    test_glitch();
    test_backpressure();
    test_back_to_back();
    test_restart();
    test_async_reset();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
